// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF challenge scheduler and its checkers.
package puf_pkg;

  localparam int unsigned CHAL_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RDY = 3'd2,
    RESP     = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  // Bits needed to hold a Hamming weight of 0..w.
  function automatic int unsigned ones_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/puf_popcount.sv
// Combinational Hamming weight of a W-bit word.
module puf_popcount
  import puf_pkg::*;
#(
  parameter int unsigned W = CHAL_W_DEF
) (
  input  logic [W-1:0]         data,
  output logic [ones_w(W)-1:0] ones_c
);

  localparam int unsigned OW = ones_w(W);

  always_comb begin
    ones_c = '0;
    for (int i = 0; i < W; i++) begin
      ones_c = ones_c + OW'(data[i]);
    end
  end

endmodule

// File: rtl/puf_challenge_scheduler.sv
// Round-robin sharing of one RO-PUF between two requesters with a tagged,
// back-pressured response channel and timeouts on both PUF ready edges.
module puf_challenge_scheduler
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W  = CHAL_W_DEF,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  input  logic [CHAL_W-1:0]         req_chall0,
  input  logic [CHAL_W-1:0]         req_chall1,
  output logic [1:0]                req_ready,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [CHAL_W-1:0]         rsp_data,
  output logic [ones_w(CHAL_W)-1:0] rsp_ones,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      puf_en,
  output logic [CHAL_W-1:0]         puf_chall,
  input  logic [CHAL_W-1:0]         puf_response,
  input  logic                      puf_ready,
  output logic                      busy
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ONES_W = ones_w(CHAL_W);

  state_e              state_q, state_d;
  logic [CHAL_W-1:0]   chall_r, chall_d;
  logic                id_r, id_d;
  logic                rr_last, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_err, sticky_d;

  logic [1:0]          req_ready_d;
  logic                rsp_valid_d, rsp_id_d, rsp_err_d, puf_en_d, busy_d;
  logic [CHAL_W-1:0]   rsp_data_d, puf_chall_d;
  logic [ONES_W-1:0]   rsp_ones_d, ones_c;

  logic [1:0]          grant_c;
  logic                timeout_c;

  puf_popcount #(.W(CHAL_W)) u_popcount (
    .data   (puf_response),
    .ones_c (ones_c)
  );

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_c = req_valid;
    if (req_valid == 2'b11) begin
      grant_c = rr_last ? 2'b01 : 2'b10;
    end
  end

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|req_valid) state_d = ISSUE;
      ISSUE:    state_d = WAIT_RDY;
      WAIT_RDY: if (puf_ready || timeout_c) state_d = RESP;
      RESP:     if (rsp_ready) state_d = DRAIN;
      DRAIN:    if (!puf_ready || timeout_c) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    chall_d     = chall_r;
    id_d        = id_r;
    rr_d        = rr_last;
    cnt_d       = cnt_q;
    sticky_d    = sticky_err;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    rsp_ones_d  = rsp_ones;
    rsp_err_d   = rsp_err;
    puf_en_d    = puf_en;
    puf_chall_d = puf_chall;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d = grant_c;
          chall_d     = grant_c[1] ? req_chall1 : req_chall0;
          id_d        = grant_c[1];
          rr_d        = grant_c[1];
        end
      end
      ISSUE: begin
        puf_en_d    = 1'b1;
        puf_chall_d = chall_r;
        cnt_d       = '0;
      end
      WAIT_RDY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (puf_ready) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_r;
          rsp_data_d  = puf_response;
          rsp_ones_d  = ones_c;
          rsp_err_d   = 1'b0;
        end else if (timeout_c) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_r;
          rsp_data_d  = '0;
          rsp_ones_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          puf_en_d    = 1'b0;
          cnt_d       = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (puf_ready && timeout_c) begin
          sticky_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chall_r    <= '0;
      id_r       <= 1'b0;
      rr_last    <= 1'b1;
      cnt_q      <= '0;
      sticky_err <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_ones   <= '0;
      rsp_err    <= 1'b0;
      puf_en     <= 1'b0;
      puf_chall  <= '0;
      busy       <= 1'b0;
    end else begin
      chall_r    <= chall_d;
      id_r       <= id_d;
      rr_last    <= rr_d;
      cnt_q      <= cnt_d;
      sticky_err <= sticky_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_data   <= rsp_data_d;
      rsp_ones   <= rsp_ones_d;
      rsp_err    <= rsp_err_d;
      puf_en     <= puf_en_d;
      puf_chall  <= puf_chall_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_puf_challenge_scheduler.sv
// Scoreboard bench for puf_challenge_scheduler with a behavioural RO-PUF model.
module tb_puf_challenge_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_chall0, req_chall1;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_ones;
  logic       puf_en, puf_ready, busy;
  logic [7:0] puf_chall, puf_response;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic [3:0] ones;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_rr;

  int         puf_mode;   // 0 normal, 1 ready stuck low, 2 ready stuck high
  int         model_lat;
  int         en_cnt;
  logic [7:0] model_resp;

  puf_challenge_scheduler #(.CHAL_W(8), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_chall0   (req_chall0),
    .req_chall1   (req_chall1),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ones     (rsp_ones),
    .rsp_err      (rsp_err),
    .rsp_ready    (rsp_ready),
    .puf_en       (puf_en),
    .puf_chall    (puf_chall),
    .puf_response (puf_response),
    .puf_ready    (puf_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // RO-PUF model: ready rises model_lat cycles after en, falls once en drops.
  always @(negedge clk) begin
    case (puf_mode)
      1: puf_ready = 1'b0;
      2: begin
        puf_ready    = 1'b1;
        puf_response = model_resp;
      end
      default: begin
        if (puf_en) begin
          en_cnt = en_cnt + 1;
          if (en_cnt >= model_lat) begin
            puf_ready    = 1'b1;
            puf_response = model_resp;
          end
        end else begin
          en_cnt    = 0;
          puf_ready = 1'b0;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] hw8(input logic [7:0] d);
    logic [7:0] v;
    logic [3:0] n;
    v = d;
    n = 4'd0;
    while (v != 8'd0) begin
      v = v & (v - 8'd1);
      n = n + 4'd1;
    end
    return n;
  endfunction

  task automatic run_txn(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] resp, input int bp, input logic [1:0] extra,
                         input logic exp_err);
    logic       exp_id;
    logic [1:0] oh;
    logic [7:0] wc;
    exp_t       e, got;
    int         n, bad, unstable;
    exp_id = (v == 2'b11) ? ~exp_rr : v[1];
    oh     = exp_id ? 2'b10 : 2'b01;
    wc     = exp_id ? c1 : c0;
    e.id   = exp_id;
    e.err  = exp_err;
    e.data = exp_err ? 8'h00 : resp;
    e.ones = exp_err ? 4'd0 : hw8(resp);
    exp_q.push_back(e);
    model_resp = resp;
    req_chall0 = c0;
    req_chall1 = c1;
    req_valid  = v;
    rsp_ready  = 1'b0;
    bad = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (req_ready == 2'b00 && n < 20);
    check("grant", 32'(req_ready), 32'(oh));
    exp_rr    = exp_id;
    req_valid = (v & ~oh) | extra;
    if (exp_id) req_chall1 = ~c1;
    else        req_chall0 = ~c0;
    n = 0;
    do begin
      step();
      n++;
      if (req_ready != 2'b00) bad++;
    end while (!puf_en && n < 10);
    check("puf_en_up", 32'(puf_en), 1);
    check("puf_chall", 32'(puf_chall), 32'(wc));
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
      if (req_ready != 2'b00) bad++;
    end
    check("rsp_valid", 32'(rsp_valid), 1);
    if (exp_err) check("timeout_cycles", 32'(n), 16);
    got = {rsp_id, rsp_data, rsp_ones, rsp_err};
    unstable = 0;
    for (int i = 0; i < bp; i++) begin
      step();
      if ({rsp_id, rsp_data, rsp_ones, rsp_err} != got || !rsp_valid || !puf_en || req_ready != 2'b00)
        unstable++;
    end
    if (bp > 0) check("bp_stable", 32'(unstable), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_id", 32'(got.id), 32'(e.id));
      check("rsp_data", 32'(got.data), 32'(e.data));
      check("rsp_ones", 32'(got.ones), 32'(e.ones));
      check("rsp_err", 32'(got.err), 32'(e.err));
    end else begin
      check("scoreboard_empty", 1, 0);
    end
    check("rsp_drop", 32'(rsp_valid), 0);
    check("puf_en_drop", 32'(puf_en), 0);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
      if (req_ready != 2'b00) bad++;
    end
    check("back_to_idle", 32'(busy), 0);
    check("no_grant_busy", 32'(bad), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int leaks;
    rst          = 1'b0;
    req_valid    = 2'b00;
    req_chall0   = 8'h00;
    req_chall1   = 8'h00;
    rsp_ready    = 1'b0;
    puf_ready    = 1'b0;
    puf_response = 8'h00;
    puf_mode     = 0;
    model_lat    = 5;
    en_cnt       = 0;
    model_resp   = 8'h00;
    exp_rr       = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_ones, rsp_err, puf_en}), 0);
    check("rst_puf_chall", 32'(puf_chall), 0);
    check("rst_sticky", 32'(dut.sticky_err), 0);
    rst = 1'b1;
    step();

    // Single request
    run_txn(2'b01, 8'b1101_0100, 8'h00, 8'hA5, 0, 2'b00, 1'b0);
    // Back-pressure with requester 1 waiting meanwhile, then serve it
    run_txn(2'b01, 8'h9E, 8'h61, 8'h3C, 20, 2'b10, 1'b0);
    run_txn(2'b10, 8'h9E, 8'h61, 8'h0F, 0, 2'b00, 1'b0);
    // Contention: grants alternate 0,1,0,1
    run_txn(2'b11, 8'h52, 8'h16, 8'h81, 0, 2'b00, 1'b0);
    run_txn(2'b11, 8'h52, 8'h16, 8'h7E, 0, 2'b00, 1'b0);
    run_txn(2'b11, 8'h52, 8'h16, 8'h33, 0, 2'b00, 1'b0);
    run_txn(2'b11, 8'h52, 8'h16, 8'hC8, 0, 2'b00, 1'b0);
    req_valid = 2'b00;
    // Popcount corners
    run_txn(2'b01, 8'h11, 8'h00, 8'h00, 0, 2'b00, 1'b0);
    run_txn(2'b01, 8'h22, 8'h00, 8'hFF, 0, 2'b00, 1'b0);
    run_txn(2'b01, 8'h44, 8'h00, 8'hE7, 0, 2'b00, 1'b0);
    // Ready stuck low: response timeout
    puf_mode = 1;
    run_txn(2'b01, 8'h77, 8'h00, 8'hAB, 0, 2'b00, 1'b1);
    // Ready stuck high: drain timeout sets the sticky error
    puf_mode = 2;
    check("sticky_before", 32'(dut.sticky_err), 0);
    run_txn(2'b10, 8'h00, 8'h5A, 8'hC3, 0, 2'b00, 1'b0);
    check("sticky_after", 32'(dut.sticky_err), 1);
    puf_mode = 0;
    step();
    step();

    // Async reset in the middle of WAIT_RDY
    puf_mode   = 1;
    req_chall0 = 8'h3C;
    req_valid  = 2'b01;
    n = 0;
    do begin
      step();
      n++;
    end while (req_ready == 2'b00 && n < 20);
    req_valid = 2'b00;
    n = 0;
    do begin
      step();
      n++;
    end while (!puf_en && n < 10);
    step();
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_puf_en", 32'(puf_en), 0);
    check("async_rst_puf_chall", 32'(puf_chall), 0);
    check("async_rst_rsp", 32'({req_ready, rsp_valid, rsp_data, rsp_ones, rsp_err}), 0);
    #12;
    rst = 1'b1;
    puf_mode = 0;
    leaks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || busy) leaks++;
    end
    check("no_rsp_after_rst", 32'(leaks), 0);
    exp_rr = 1'b1;
    run_txn(2'b11, 8'hB2, 8'h4D, 8'h96, 0, 2'b00, 1'b0);
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
